// File: rtl/mux_n1_zero_pipe.sv
// Per-lane N:1 word select with forced-zero codes; optional MUX_SEL_ERR_EN adds sticky sel_err.
// Latency: 2 register stages (group pre-select, then group/zero select).
// Backpressure: elastic valid/ready, one slot per stage; in_ready is combinational from out_ready.
module mux_n1_zero_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IN     = 16,
    parameter int NUM_LANE   = 4,
    localparam int SEL_WIDTH = $clog2(NUM_IN) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_vec,
    input  logic [NUM_LANE*SEL_WIDTH-1:0]  in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_LANE*DATA_WIDTH-1:0] out_vec,
    output logic [NUM_LANE-1:0]            out_zero,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic                           sel_err
`endif
);

    localparam int NUM_GRP = NUM_IN / 4;
    localparam int GIDX_W  = SEL_WIDTH - 2;

    logic                  v1_q;
    logic                  v2_q;
    logic                  adv2;
    logic                  xfer_in;
    logic                  load2;

    logic [DATA_WIDTH-1:0] grp_d  [NUM_LANE][NUM_GRP];
    logic [DATA_WIDTH-1:0] grp_q  [NUM_LANE][NUM_GRP];
    logic [GIDX_W-1:0]     gidx_d [NUM_LANE];
    logic [GIDX_W-1:0]     gidx_q [NUM_LANE];

    logic [NUM_LANE*DATA_WIDTH-1:0] out_vec_d;
    logic [NUM_LANE*DATA_WIDTH-1:0] out_vec_q;
    logic [NUM_LANE-1:0]            out_zero_d;
    logic [NUM_LANE-1:0]            out_zero_q;

    function automatic logic [DATA_WIDTH-1:0] pick_word(
        input logic [NUM_IN*DATA_WIDTH-1:0] vec,
        input int                           grp,
        input logic [1:0]                   lo
    );
        return vec[(4*grp + int'(lo))*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign adv2     = ~v2_q | out_ready;
    assign in_ready = ~v1_q | adv2;
    assign xfer_in  = in_valid & in_ready;
    assign load2    = adv2 & v1_q;

    // Stage 1: low select bits pick one word inside every group of four.
    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            gidx_d[l] = in_sel[l*SEL_WIDTH+2 +: GIDX_W];
            for (int g = 0; g < NUM_GRP; g++) begin
                grp_d[l][g] = pick_word(in_vec, g, in_sel[l*SEL_WIDTH +: 2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            for (int l = 0; l < NUM_LANE; l++) begin
                gidx_q[l] <= '0;
                for (int g = 0; g < NUM_GRP; g++) begin
                    grp_q[l][g] <= '0;
                end
            end
        end else begin
            if (in_ready) begin
                v1_q <= in_valid;
            end
            if (xfer_in) begin
                for (int l = 0; l < NUM_LANE; l++) begin
                    gidx_q[l] <= gidx_d[l];
                    for (int g = 0; g < NUM_GRP; g++) begin
                        grp_q[l][g] <= grp_d[l][g];
                    end
                end
            end
        end
    end

    // Stage 2: a group index past the last group is any code >= NUM_IN, i.e. a zero code.
    always_comb begin
        out_vec_d  = '0;
        out_zero_d = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            out_zero_d[l] = (int'(gidx_q[l]) >= NUM_GRP);
            for (int g = 0; g < NUM_GRP; g++) begin
                if (int'(gidx_q[l]) == g) begin
                    out_vec_d[l*DATA_WIDTH +: DATA_WIDTH] = grp_q[l][g];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q       <= 1'b0;
            out_vec_q  <= '0;
            out_zero_q <= '0;
        end else begin
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (load2) begin
                out_vec_q  <= out_vec_d;
                out_zero_q <= out_zero_d;
            end
        end
    end

    assign out_vec   = out_vec_q;
    assign out_zero  = out_zero_q;
    assign out_valid = v2_q;

`ifdef MUX_SEL_ERR_EN
    logic sel_oor;
    logic sel_err_q;

    always_comb begin
        sel_oor = 1'b0;
        for (int l = 0; l < NUM_LANE; l++) begin
            if (int'(in_sel[l*SEL_WIDTH +: SEL_WIDTH]) > NUM_IN) begin
                sel_oor = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (xfer_in && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n1_zero_pipe.sv
// Bench for mux_n1_zero_pipe: default instance plus a NUM_IN=8, NUM_LANE=1 instance.
module tb_mux_n1_zero_pipe;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in_vec = '0;
    logic [19:0]  in_sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  out_vec;
    logic [3:0]   out_zero;
    logic         out_valid;
    logic         out_ready = 1'b1;

    logic [63:0]  s_in_vec = '0;
    logic [3:0]   s_in_sel = '0;
    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [7:0]   s_out_vec;
    logic [0:0]   s_out_zero;
    logic         s_out_valid;
`ifdef MUX_SEL_ERR_EN
    logic         sel_err;
    logic         s_sel_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_n1_zero_pipe dut (
        .clk(clk), .reset(reset), .in_vec(in_vec), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_vec(out_vec),
        .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    mux_n1_zero_pipe #(.DATA_WIDTH(8), .NUM_IN(8), .NUM_LANE(1)) dut_s (
        .clk(clk), .reset(reset), .in_vec(s_in_vec), .in_sel(s_in_sel),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_vec(s_out_vec),
        .out_zero(s_out_zero), .out_valid(s_out_valid), .out_ready(1'b1)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(s_sel_err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: words are numbered k = 0..15; any code >= 16 yields zero.
    function automatic logic [31:0] model_vec(input logic [127:0] v, input logic [19:0] s);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++) begin
            int code = int'(s[l*5 +: 5]);
            if (code < 16) r[l*8 +: 8] = v[code*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] model_zero(input logic [19:0] s);
        logic [3:0] r = '0;
        for (int l = 0; l < 4; l++) r[l] = (int'(s[l*5 +: 5]) >= 16);
        return r;
    endfunction

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(base + k);
        return v;
    endfunction

    function automatic logic [19:0] sel4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    logic [31:0] q_vec[$];
    logic [3:0]  q_zero[$];
    logic        hold_pend = 1'b0;
    logic [31:0] hold_vec;
    logic [3:0]  hold_zero;
    int          pops = 0;

    always @(negedge clk) begin
        if (reset) begin
            q_vec.delete();
            q_zero.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_vec", out_vec, hold_vec);
                check("stall_hold_zero", out_zero, hold_zero);
            end
            hold_pend = out_valid && !out_ready;
            hold_vec  = out_vec;
            hold_zero = out_zero;
            if (out_valid && out_ready) begin
                if (q_vec.size() == 0) begin
                    check("stale_beat", out_valid, 0);
                end else begin
                    check("out_vec", out_vec, q_vec.pop_front());
                    check("out_zero", out_zero, q_zero.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                q_vec.push_back(model_vec(in_vec, in_sel));
                q_zero.push_back(model_zero(in_sel));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] v, input logic [19:0] s, output int cycles);
        logic acc = 1'b0;
        cycles = 0;
        in_vec = v;
        in_sel = s;
        in_valid = 1'b1;
        while (!acc && cycles < 64) begin
            @(negedge clk);
            acc = in_ready;
            step();
            cycles++;
        end
        check("send_accept", acc, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int pops0;

        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_in_ready", in_ready, 1);
        step();

        // Single beat: sel {0,5,15,16} on ramp 0x10.
        send(ramp(8'h10), sel4(0, 5, 15, 16), n);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_early", out_valid, 0);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_vec", out_vec, 32'h001F1510);
        check("t1_zero", out_zero, 4'b1000);
        @(negedge clk);
        check("t1_valid_once", out_valid, 0);
        step();

        // 20-beat stream, codes 0..19 on every lane.
        for (int i = 0; i < 20; i++) begin
            send(ramp(8'h20 + 3*i), sel4(i, i, i, i), n);
            check("stream_no_stall", n, 1);
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("stream_drained", q_vec.size(), 0);

        // Backpressure: two beats fill the pipe, third waits.
        out_ready = 1'b0;
        send(ramp(8'h40), sel4(3, 17, 8, 16), n);
        send(ramp(8'h60), sel4(1, 2, 18, 15), n);
        in_vec = ramp(8'h80);
        in_sel = sel4(16, 0, 9, 4);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_vec", out_vec, 32'h00480043);
        check("full_out_zero", out_zero, 4'b1010);
        repeat (3) @(posedge clk);
        #1;
        pops0 = pops;
        out_ready = 1'b1;
        send(ramp(8'h80), sel4(16, 0, 9, 4), n);
        in_valid = 1'b0;
        repeat (5) step();
        check("drain_count", pops - pops0, 3);
        check("drain_empty", q_vec.size(), 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(ramp(8'hA0), sel4(1, 1, 1, 1), n);
        send(ramp(8'hB0), sel4(2, 2, 2, 2), n);
        in_valid = 1'b0;
        pulse_reset();
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_vec", out_vec, 0);
        check("mid_rst_out_zero", out_zero, 0);
        check("mid_rst_in_ready", in_ready, 1);
        step();
        out_ready = 1'b1;
        repeat (6) step();
        check("mid_rst_pops", q_vec.size(), 0);

        // Reduced instance: NUM_IN=8, one lane.
        for (int k = 0; k < 8; k++) s_in_vec[k*8 +: 8] = 8'hA0 + 8'(k);
        for (int t = 0; t < 3; t++) begin
            logic [3:0] code;
            code = (t == 0) ? 4'd7 : (t == 1) ? 4'd8 : 4'd12;
            s_in_sel = code;
            s_in_valid = 1'b1;
            step();
            s_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("small_valid", s_out_valid, 1);
            check("small_vec", s_out_vec, (t == 0) ? 8'hA7 : 8'h00);
            check("small_zero", s_out_zero, (t == 0) ? 1'b0 : 1'b1);
            step();
        end

`ifdef MUX_SEL_ERR_EN
        pulse_reset();
        @(negedge clk);
        check("sel_err_reset", sel_err, 0);
        step();
        send(ramp(8'h30), sel4(16, 16, 0, 1), n);
        in_valid = 1'b0;
        @(negedge clk);
        check("sel_err_code16", sel_err, 0);
        step();
        send(ramp(8'h30), sel4(0, 1, 17, 2), n);
        in_valid = 1'b0;
        @(negedge clk);
        check("sel_err_set", sel_err, 1);
        step();
        send(ramp(8'h50), sel4(4, 5, 6, 7), n);
        in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("sel_err_sticky", sel_err, 1);
        step();
        pulse_reset();
        @(negedge clk);
        check("sel_err_cleared", sel_err, 0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
